// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter.
// Shifter state encoding, default idle level, counter width helper.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_BIT_DEF = 1'b0;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: WIDTH-bit words in over valid/ready,
// one bit per clock out on sout, MSB- or LSB-first per word.
// Ports: clk, rst (async active-low); din/din_valid/lsb_first/din_ready
// input handshake; sout/sout_valid/frame_done serial side; busy status.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             lsb_first,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             lsb_q, lsb_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hlsb_q, hlsb_d;
  logic             hfull_q, hfull_d;
  logic             sout_q, sout_d;
  logic             sv_q, sv_d;
  logic             fd_q, fd_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;

  logic             last, free, accept;
  logic             load, go_idle, shift, to_hold;
  logic [WIDTH-1:0] ld_w;
  logic             ld_lsb;

  always_comb begin
    last    = (state_q == ST_SHIFT) && (cnt_q == LAST);
    free    = (state_q == ST_IDLE) || last;
    accept  = din_valid && rdy_q;
    // Held word has priority; a fresh word only bypasses when hold is empty.
    load    = free && (hfull_q || accept);
    go_idle = last && !hfull_q && !accept;
    shift   = (state_q == ST_SHIFT) && !last;
    to_hold = accept && !free;
    ld_w    = hfull_q ? hold_q : din;
    ld_lsb  = hfull_q ? hlsb_q : lsb_first;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    lsb_d   = lsb_q;
    hold_d  = hold_q;
    hlsb_d  = hlsb_q;
    hfull_d = hfull_q;
    sout_d  = sout_q;
    sv_d    = sv_q;
    fd_d    = 1'b0;
    unique case (1'b1)
      load: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
        lsb_d   = ld_lsb;
        sout_d  = ld_lsb ? ld_w[0] : ld_w[WIDTH-1];
        sh_d    = ld_lsb ? (ld_w >> 1) : (ld_w << 1);
        sv_d    = 1'b1;
        hfull_d = 1'b0;
      end
      go_idle: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sout_d  = IDLE_BIT;
        sv_d    = 1'b0;
      end
      shift: begin
        cnt_d  = cnt_q + 1'b1;
        sout_d = lsb_q ? sh_q[0] : sh_q[WIDTH-1];
        sh_d   = lsb_q ? (sh_q >> 1) : (sh_q << 1);
        fd_d   = (cnt_q == LAST_M1);
      end
      default: ;
    endcase
    if (to_hold) begin
      hold_d  = din;
      hlsb_d  = lsb_first;
      hfull_d = 1'b1;
    end
    rdy_d  = !hfull_d;
    busy_d = (state_d == ST_SHIFT) || hfull_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      lsb_q   <= 1'b0;
      hold_q  <= '0;
      hlsb_q  <= 1'b0;
      hfull_q <= 1'b0;
      sout_q  <= IDLE_BIT;
      sv_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      lsb_q   <= lsb_d;
      hold_q  <= hold_d;
      hlsb_q  <= hlsb_d;
      hfull_q <= hfull_d;
      sout_q  <= sout_d;
      sv_q    <= sv_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign din_ready  = rdy_q;
  assign sout       = sout_q;
  assign sout_valid = sv_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: table vectors, scoreboard of serial bits,
// hand sequences for back-to-back, backpressure, reset and 1010 detection.
module tb_serial_frame_tx;

  localparam int   W      = 8;
  localparam logic IDLE_B = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         lsb_first = 1'b0;
  logic         din_ready, sout, sout_valid, frame_done, busy;

  serial_frame_tx #(.WIDTH(W), .IDLE_BIT(IDLE_B)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .lsb_first  (lsb_first),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic last;
  } bit_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [7:0] e;
  } vec_t;

  bit_t q[$];
  int   fd_times[$];
  int   det_hits[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   run = 0;
  int   maxrun = 0;
  int   seen = 0;
  logic [3:0] det_sh = '0;
  int   det_pos = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] expb(input logic [7:0] d, input logic l);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[7-k] = l ? d[k] : d[7-k];
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      bit_t e;
      cyc++;
      if (sout_valid) begin
        run++;
        if (run > maxrun) maxrun = run;
        seen++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit got sout=%0b want none", sout);
        end else begin
          e = q.pop_front();
          if (sout !== e.b || frame_done !== e.last) begin
            errors++;
            $display("FAIL serial_bit got %0b/%0b want %0b/%0b",
                     sout, frame_done, e.b, e.last);
          end
        end
        det_sh = {det_sh[2:0], sout};
        det_pos++;
        if (det_pos >= 4 && det_sh == 4'b1010) det_hits.push_back(det_pos);
        if (frame_done) fd_times.push_back(cyc);
      end else begin
        run = 0;
        checks++;
        if (sout !== IDLE_B || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL idle_out got %0b/%0b want %0b/0",
                   sout, frame_done, IDLE_B);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l,
                      input logic [7:0] e, output int waits);
    din = d;
    lsb_first = l;
    din_valid = 1'b1;
    waits = 0;
    while (!din_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!din_ready) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout got ready=0 want 1");
    end
    @(posedge clk);
    for (int k = 0; k < 8; k++)
      q.push_back('{b: e[7-k], last: (k == 7)});
    @(negedge clk);
  endtask

  task automatic idle();
    din_valid = 1'b0;
    din = 'x;
    lsb_first = 1'bx;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {31'd0, (n < 100)}, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("svalid_after", {31'd0, sout_valid}, 32'd0);
  endtask

  vec_t tbl[5];

  initial begin
    int w, base, n;
    logic [7:0] rd;
    logic rl;

    tbl[0] = '{d: 8'hA5, l: 1'b0, e: 8'b10100101};
    tbl[1] = '{d: 8'h0A, l: 1'b1, e: 8'b01010000};
    tbl[2] = '{d: 8'h3C, l: 1'b1, e: 8'b00111100};
    tbl[3] = '{d: 8'h81, l: 1'b0, e: 8'b10000001};
    tbl[4] = '{d: 8'h01, l: 1'b1, e: 8'b10000000};

    repeat (3) @(negedge clk);
    chk("rst_sout", {31'd0, sout}, {31'd0, IDLE_B});
    chk("rst_svalid", {31'd0, sout_valid}, 32'd0);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, din_ready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].d, tbl[i].l, tbl[i].e, w);
      chk("single_busy", {31'd0, busy}, 32'd1);
      idle();
      drain();
    end

    fd_times.delete();
    maxrun = 0;
    send(8'hF0, 1'b0, 8'hF0, w);
    send(8'h0F, 1'b0, 8'h0F, w);
    chk("b2b_ready_low", {31'd0, din_ready}, 32'd0);
    send(8'hAA, 1'b0, 8'hAA, w);
    idle();
    drain();
    chk("b2b_pulses", fd_times.size(), 32'd3);
    if (fd_times.size() == 3) begin
      chk("b2b_gap1", fd_times[1] - fd_times[0], 32'd8);
      chk("b2b_gap2", fd_times[2] - fd_times[1], 32'd8);
    end
    chk("b2b_run", maxrun, 32'd24);

    send(8'h3C, 1'b1, 8'b00111100, w);
    idle();
    repeat (2) @(negedge clk);
    send(8'hC3, 1'b1, 8'b11000011, w);
    send(8'h5A, 1'b0, 8'h5A, w);
    chk("bp_wait", w, 32'd5);
    idle();
    drain();

    base = seen;
    send(8'hA5, 1'b0, 8'hA5, w);
    send(8'h55, 1'b0, 8'h55, w);
    idle();
    n = 0;
    while (seen < base + 4 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_reach_bit3", {31'd0, (seen == base + 4)}, 32'd1);
    mon_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_sout", {31'd0, sout}, {31'd0, IDLE_B});
    chk("arst_svalid", {31'd0, sout_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {31'd0, din_ready}, 32'd1);
    q.delete();
    #10 rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    det_sh = '0;
    det_pos = 0;
    det_hits.delete();
    send(8'hAA, 1'b0, 8'hAA, w);
    idle();
    drain();
    chk("det_count", det_hits.size(), 32'd3);
    if (det_hits.size() == 3) begin
      chk("det_hit0", det_hits[0], 32'd4);
      chk("det_hit1", det_hits[1], 32'd6);
      chk("det_hit2", det_hits[2], 32'd8);
    end

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      rl = 1'($urandom_range(0, 1));
      send(rd, rl, expb(rd, rl), w);
    end
    idle();
    drain();
    chk("sb_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
